// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO,
// decoding a 16-byte register window on the CPU data-memory port.
module mmio_uart_tx #(
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        we,
    output logic        hit,
    output logic [31:0] read_data,
    output logic        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count, w_count_nxt;
    logic [CW-1:0] r_baud, w_baud_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_tx, w_tx_nxt, r_ovf, r_en;
    logic          w_wr_data, w_wr_status, w_wr_ctrl;
    logic          w_full, w_empty, w_busy, w_push, w_reject, w_pop;
    logic          w_can_pop, w_baud_end, w_unused;

    assign hit         = address[31:4] == BASE_ADDR[31:4];
    assign w_wr_data   = we && hit && address[3:2] == 2'd0;
    assign w_wr_status = we && hit && address[3:2] == 2'd1;
    assign w_wr_ctrl   = we && hit && address[3:2] == 2'd2;
    assign w_full      = r_count == (AW+1)'(FIFO_DEPTH);
    assign w_empty     = r_count == '0;
    assign w_busy      = r_state != S_IDLE || !w_empty;
    // Push is judged on the pre-edge count, so a same-cycle pop never frees a slot for it
    assign w_push      = w_wr_data && !w_full;
    assign w_reject    = w_wr_data && w_full;
    assign w_can_pop   = r_en && !w_empty;
    assign w_baud_end  = r_baud == CW'(CLK_DIV - 1);
    assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign tx          = r_tx;
    assign w_unused    = ^{address[1:0], write_data[31:8]};

    assign read_data = !hit ? '0
                     : address[3:2] == 2'd1 ? {16'd0, 8'(r_count), 4'd0, r_ovf, w_busy, w_empty, w_full}
                     : address[3:2] == 2'd2 ? {31'd0, r_en}
                     : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE:  if (w_can_pop) begin
                         w_pop       = 1'b1;
                         w_state_nxt = S_START;
                     end
            S_START: if (w_baud_end) w_state_nxt = S_DATA;
            S_DATA:  if (w_baud_end && r_bit == 3'd7) w_state_nxt = S_STOP;
            S_STOP:  if (w_baud_end) begin
                         w_pop       = w_can_pop;
                         w_state_nxt = w_can_pop ? S_START : S_IDLE;
                     end
            default: w_state_nxt = S_IDLE;
        endcase
        w_baud_nxt  = (r_state == S_IDLE || w_baud_end) ? '0 : r_baud + 1'b1;
        w_bit_nxt   = r_state != S_DATA ? '0 : w_baud_end ? r_bit + 1'b1 : r_bit;
        w_shift_nxt = w_pop ? r_mem[r_rd_ptr] : r_shift;
        // tx is registered from the next state so the line changes on the same edge as the FSM
        w_tx_nxt    = w_state_nxt == S_START ? 1'b0
                    : w_state_nxt == S_DATA  ? w_shift_nxt[w_bit_nxt]
                    : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_tx     <= 1'b1;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
            r_en     <= 1'b1;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_tx     <= w_tx_nxt;
            r_count  <= w_count_nxt;
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_ovf    <= w_reject || (r_ovf && !(w_wr_status && write_data[3]));
            r_en     <= w_wr_ctrl ? write_data[0] : r_en;
            r_baud   <= w_baud_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= write_data[7:0];
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench; a line monitor decodes every 40-cycle
// frame on tx and compares it against the bytes queued by the stimulus tasks.
module tb_mmio_uart_tx;
    localparam int          CLK_DIV = 4;
    localparam logic [31:0] BASE    = 32'hFFFF_0000;
    localparam logic [31:0] A_DATA  = BASE;
    localparam logic [31:0] A_STAT  = BASE + 32'd4;
    localparam logic [31:0] A_CTRL  = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        we = 1'b0;
    logic        hit, tx;
    logic [31:0] read_data;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          frames_done = 0;
    logic [7:0]  sb[$];
    int          starts[$];
    logic [39:0] mon_s, mon_e;
    logic [7:0]  mon_b;
    bit          mon_ab;
    int          mon_k;

    mmio_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(8), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .write_data(write_data),
        .we(we), .hit(hit), .read_data(read_data), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: samples tx on every falling clock edge across a whole frame
    initial forever begin
        @(negedge clk);
        if (rst_n && tx === 1'b0) begin
            mon_k  = cyc;
            mon_s  = '0;
            mon_ab = 1'b0;
            for (int j = 0; j < 40; j++) begin
                if (j > 0) @(negedge clk);
                if (!rst_n) begin
                    mon_ab = 1'b1;
                    break;
                end
                mon_s[j] = tx;
            end
            if (!mon_ab) begin
                n_chk++;
                if (sb.size() == 0) begin
                    $display("FAIL frame_unexpected: got frame %b at cycle %0d, required none", mon_s, mon_k);
                end else begin
                    mon_b = sb.pop_front();
                    for (int j = 0; j < 40; j++)
                        mon_e[j] = (j < 4) ? 1'b0 : (j >= 36) ? 1'b1 : mon_b[(j-4)/4];
                    if (mon_s !== mon_e)
                        $display("FAIL frame: got line %b, required %b (byte %h)", mon_s, mon_e, mon_b);
                    else
                        n_pass++;
                end
                starts.push_back(mon_k);
                frames_done++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, output int n);
        @(negedge clk);
        address = a;
        write_data = d;
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        address = '0;
        write_data = '0;
        n = cyc;
    endtask

    task automatic push(input logic [7:0] b, output int n);
        wr(A_DATA, {24'h0, b}, n);
        sb.push_back(b);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
        address = a;
        #1;
        d = read_data;
        h = hit;
        address = '0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_frames(input int n, input int limit);
        for (int i = 0; i < limit && frames_done < n; i++) @(negedge clk);
        n_chk++;
        if (frames_done < n) $display("FAIL frame_timeout: got %0d frames, required %0d", frames_done, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        int n, m;
        logic [31:0] d;
        logic h;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b, required 1", tx); else n_pass++;
        rd(A_STAT, d, h);
        n_chk++; if (d !== 32'h2) $display("FAIL reset_status: got %h, required 00000002", d); else n_pass++;
        rd(A_CTRL, d, h);
        n_chk++; if (d !== 32'h1) $display("FAIL reset_ctrl: got %h, required 00000001", d); else n_pass++;
        wr(A_DATA, 32'h0, n);
        wr(A_DATA, 32'h0, m);
        wr(A_CTRL, 32'h0, m);
        wait_cyc(n + 10);
        n_chk++; if (tx !== 1'b0) $display("FAIL midframe_tx: got %b, required 0", tx); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (tx !== 1'b1) $display("FAIL async_reset_tx: got %b, required 1", tx); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd(A_STAT, d, h);
        n_chk++; if (d !== 32'h2) $display("FAIL midreset_status: got %h, required 00000002", d); else n_pass++;
        rd(A_CTRL, d, h);
        n_chk++; if (d !== 32'h1) $display("FAIL midreset_ctrl: got %h, required 00000001", d); else n_pass++;
    endtask

    task automatic test_single();
        int n, f;
        logic [31:0] d;
        logic h;
        f = frames_done;
        push(8'h55, n);
        wait_cyc(n + 40);
        rd(A_STAT, d, h);
        n_chk++; if (d[2] !== 1'b1) $display("FAIL single_busy_stop: got %b, required 1", d[2]); else n_pass++;
        wait_cyc(n + 41);
        rd(A_STAT, d, h);
        n_chk++; if (d !== 32'h2) $display("FAIL single_idle_status: got %h, required 00000002", d); else n_pass++;
        wait_frames(f + 1, 100);
        n_chk++;
        if (starts[starts.size()-1] !== n + 1)
            $display("FAIL single_start: got cycle %0d, required %0d", starts[starts.size()-1], n + 1);
        else n_pass++;
    endtask

    task automatic test_overflow();
        int n, f;
        logic [31:0] d;
        logic h;
        f = frames_done;
        wr(A_CTRL, 32'h0, n);
        for (int i = 0; i < 8; i++) push(8'(i), n);
        wr(A_DATA, 32'h8, n);
        rd(A_STAT, d, h);
        n_chk++; if (d !== 32'h0000_080D) $display("FAIL overflow_status: got %h, required 0000080D", d); else n_pass++;
        wr(A_STAT, 32'hFFFF_FFF7, n);
        rd(A_STAT, d, h);
        n_chk++; if (d !== 32'h0000_080D) $display("FAIL overflow_keep: got %h, required 0000080D", d); else n_pass++;
        wr(A_STAT, 32'h8, n);
        rd(A_STAT, d, h);
        n_chk++; if (d !== 32'h0000_0805) $display("FAIL overflow_clear: got %h, required 00000805", d); else n_pass++;
        n_chk++; if (frames_done !== f) $display("FAIL disabled_no_tx: got %0d frames, required %0d", frames_done, f); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int m, n, b, f;
        b = starts.size();
        f = frames_done;
        wr(A_CTRL, 32'h1, m);
        wait_frames(f + 8, 8 * 40 + 60);
        n_chk++; if (starts[b] !== m + 1) $display("FAIL drain_start: got cycle %0d, required %0d", starts[b], m + 1); else n_pass++;
        for (int i = 1; i < 8; i++) begin
            n_chk++;
            if (starts[b+i] - starts[b+i-1] !== 40)
                $display("FAIL gapless_%0d: got spacing %0d, required 40", i, starts[b+i] - starts[b+i-1]);
            else n_pass++;
        end
        push(8'hA5, n);
        push(8'h3C, m);
        wait_frames(f + 10, 150);
        n_chk++;
        if (starts[b+9] - starts[b+8] !== 40)
            $display("FAIL wrap_gapless: got spacing %0d, required 40", starts[b+9] - starts[b+8]);
        else n_pass++;
    endtask

    task automatic test_disable();
        int p, q, n, f;
        logic [31:0] d;
        logic h;
        f = frames_done;
        push(8'hFF, p);
        push(8'h81, q);
        wait_cyc(p + 14);
        wr(A_CTRL, 32'h0, n);
        wait_frames(f + 1, 100);
        wait_cyc(p + 80);
        n_chk++; if (frames_done !== f + 1) $display("FAIL disable_frames: got %0d, required %0d", frames_done, f + 1); else n_pass++;
        n_chk++; if (tx !== 1'b1) $display("FAIL disable_tx: got %b, required 1", tx); else n_pass++;
        rd(A_STAT, d, h);
        n_chk++; if (d !== 32'h0000_0104) $display("FAIL disable_status: got %h, required 00000104", d); else n_pass++;
        wr(A_CTRL, 32'h1, n);
        wait_frames(f + 2, 100);
        n_chk++;
        if (starts[starts.size()-1] !== n + 1)
            $display("FAIL reenable_start: got cycle %0d, required %0d", starts[starts.size()-1], n + 1);
        else n_pass++;
        wait_cyc(n + 41);
        rd(A_STAT, d, h);
        n_chk++; if (d !== 32'h2) $display("FAIL reenable_idle: got %h, required 00000002", d); else n_pass++;
    endtask

    task automatic test_decode();
        int n, f;
        logic [31:0] d;
        logic h;
        rd(BASE + 32'h10, d, h);
        n_chk++; if (h !== 1'b0 || d !== 32'h0) $display("FAIL decode_above: got hit %b data %h, required hit 0 data 0", h, d); else n_pass++;
        rd(32'h0000_0004, d, h);
        n_chk++; if (h !== 1'b0 || d !== 32'h0) $display("FAIL decode_low: got hit %b data %h, required hit 0 data 0", h, d); else n_pass++;
        rd(BASE + 32'hC, d, h);
        n_chk++; if (h !== 1'b1 || d !== 32'h0) $display("FAIL decode_reserved: got hit %b data %h, required hit 1 data 0", h, d); else n_pass++;
        rd(A_DATA, d, h);
        n_chk++; if (h !== 1'b1 || d !== 32'h0) $display("FAIL decode_data_read: got hit %b data %h, required hit 1 data 0", h, d); else n_pass++;
        f = frames_done;
        wr(BASE + 32'h10, 32'h11, n);
        wr(32'h0000_0000, 32'h22, n);
        wr(BASE + 32'hC, 32'h33, n);
        wait_cyc(n + 60);
        n_chk++; if (frames_done !== f) $display("FAIL decode_no_tx: got %0d frames, required %0d", frames_done, f); else n_pass++;
        rd(A_STAT, d, h);
        n_chk++; if (d !== 32'h2) $display("FAIL decode_status: got %h, required 00000002", d); else n_pass++;
        wr(A_CTRL, 32'hFFFF_FFFF, n);
        rd(A_CTRL, d, h);
        n_chk++; if (d !== 32'h1) $display("FAIL ctrl_mask: got %h, required 00000001", d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_back_to_back();
        test_disable();
        test_decode();
        n_chk++; if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d pending bytes, required 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the CPU data-memory port. Decodes a 16-byte window of the CPU's `memory_address`, `memory_write` and `memory_we` outputs, and returns register read data for the top-level `memory_out` mux. Store data goes into a small TX FIFO, which a baud-rate shift FSM drains as 8N1 frames on a serial pin.

## Interface

Clocking is fixed: one clock; reset is asynchronous and active-low, ports `clk` / `rst_n`.

Parameters:
- `CLK_DIV`, default 16: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of two, ≥ 2.
- `BASE_ADDR`, default 32'hFFFF_0000: window base; low 4 bits are ignored.

Ports:
- `clk`, input, 1 bit: clock, rising edge.
- `rst_n`, input, 1 bit: asynchronous active-low reset.
- `address`, input, 32 bits: CPU data address.
- `write_data`, input, 32 bits: CPU store data.
- `we`, input, 1 bit: CPU store strobe.
- `hit`, output, 1 bit: combinational; `address[31:4] == BASE_ADDR[31:4]`.
- `read_data`, output, 32 bits: combinational register read; 0 when `hit` is 0.
- `tx`, output, 1 bit: serial line, registered, idle high.

## Operation

Register map, selected by `address[3:2]` when `hit` is 1:
- 0x0 DATA: write pushes `write_data[7:0]` into the FIFO; reads as 0.
- 0x4 STATUS (read):
  - bit0 full (`count == FIFO_DEPTH`)
  - bit1 empty
  - bit2 busy (FSM not IDLE or FIFO not empty)
  - bit3 overflow (sticky)
  - bits[15:8] count
  - Writing 1 to bit3 clears overflow; other bits ignore writes.
- 0x8 CTRL: bit0 enable, read/write; other bits read 0.
- 0xC: reserved; reads 0, writes ignored.

FIFO:
- Circular buffer with read/write pointers and a count register.
- Push is taken only when `we & hit & DATA` and `count < FIFO_DEPTH`, evaluated on the pre-edge count. A same-cycle pop does not make room for that push.
- A rejected push sets overflow. If an overflow-setting push and an overflow-clearing write occur in the same cycle, set wins. (This cannot happen with a single address port, but the logic must still resolve it this way.)
- Pointers wrap modulo `FIFO_DEPTH`.
- Simultaneous push and pop leaves count unchanged.

Shift FSM:
- States: IDLE, START, DATA, STOP.
- A bit counter `baud_cnt` runs 0..CLK_DIV-1; a bit index `bit_idx` runs 0..7.
- IDLE: `tx`=1. If enable=1 and count>0, pop the head into `shift_reg` and go to START.
- START: `tx`=0 for CLK_DIV cycles, then go to DATA with `bit_idx`=0.
- DATA: `tx`=`shift_reg[bit_idx]`, LSB first, each bit held CLK_DIV cycles. After bit 7, go to STOP.
- STOP: `tx`=1 for CLK_DIV cycles.
  - At the end, if enable=1 and count>0, pop and go directly to START, giving gapless frames.
  - Otherwise go to IDLE.
- Clearing enable mid-frame does not abort the frame. It only blocks the next pop.
- Writes to DATA while the FSM is active simply queue.

Reset (asynchronous, all state):
- FSM = IDLE, `tx`=1.
- FIFO empty, pointers 0, overflow=0, enable=1.
- `baud_cnt`=0, `bit_idx`=0.
- Reset mid-frame truncates the frame immediately: `tx` goes high asynchronously and queued bytes are discarded.

## Timing

- Register writes take effect at the rising edge where `we` is sampled high. STATUS and CTRL reflect them in the following cycle.
- Read path is purely combinational from `address` and register state, with no wait states, matching the single-cycle core.
- Push at edge N into an empty FIFO with the FSM IDLE and enabled:
  - pop and transition to START at edge N+1
  - `tx` falls at edge N+1
- A frame occupies exactly 10·CLK_DIV cycles from the `tx` falling edge to the end of stop.
- Back-to-back frames have no idle cycle between the stop bit and the next start bit.
- busy drops in the cycle after the FSM re-enters IDLE with an empty FIFO.

## Test plan

Run all scenarios with `CLK_DIV`=4, `FIFO_DEPTH`=8, `BASE_ADDR`=32'hFFFF_0000.

- **Reset values:** assert `rst_n`=0 mid-run, then release → `tx`=1; STATUS = 0x0000_0002 (empty); CTRL=1.
- **Single frame:** store 0x55 to 0xFFFF_0000 at edge N → `tx` low from N+1 for 4 cycles. Then data bits 1,0,1,0,1,0,1,0, 4 cycles each. Then high for 4 cycles. busy=0 at N+41.
- **FIFO fill and overflow:** with CTRL=0, write bytes 0x00..0x08 (9 stores) → STATUS count=8, full=1, overflow=1. Write 0x8 to STATUS → overflow=0, count still 8.
- **Gapless drain and wrap:** re-enable with CTRL=1 → 8 contiguous 40-cycle frames carrying 0x00..0x07, no idle between them. Then push 0xA5 and 0x3C → the wrapped pointers deliver them in order.
- **Disable mid-frame:** push 0xFF and 0x81, then clear enable during the first frame's DATA state → 0xFF completes, `tx` stays high, count=1. Re-enabling sends 0x81.
- **Address decode:** read 0xFFFF_0010 and 0x0000_0004 → `hit`=0, `read_data`=0. Stores to those addresses → no FIFO change.
